alu_mul_ctrl: RTL and testbench
===============================

Name: alu_mul_ctrl

Overview:
- Sequencing controller for the radix-4 Booth multiplier datapath and its iteration unit.
- Accepts M-extension multiply requests from the execute stage through a valid/ready handshake.
- Sign/zero-extends the operands to W bits, pulses load, holds mact until done, selects the result half, and returns the result through a second valid/ready handshake.
- Sits between the EX-stage issue logic and the multiplier datapath. It owns no product arithmetic.

Parameters:
- XLEN, 32: operand and result width.
- W, 34: multiplier operand width (XLEN+2, Booth-extended).
- OPW, 2: op encoding width.

Ports:
- clk  in  1  system clock.
- a_rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  multiply request valid.
- req_ready  out  1  controller can accept a request.
- req_op  in  OPW  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_rs1  in  XLEN  multiplicand.
- req_rs2  in  XLEN  multiplier.
- req_flush  in  1  synchronous kill of any in-flight operation.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  XLEN  registered result.
- busy  out  1  high in any state other than IDLE.
- mu_load  out  1  one-cycle load pulse to the datapath and iteration counter.
- mu_mact  out  1  multiply-active qualifier.
- mu_res_sel  out  1  0 selects the low product half, 1 selects the high half.
- mu_zero  out  1  registered flag: either operand is zero.
- mu_op_a  out  W  extended multiplicand.
- mu_op_b  out  W  extended multiplier.
- mu_done  in  1  iteration unit completion.
- mu_result  in  XLEN  selected product half.

Behaviour:
- Reset (a_rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except req_ready=1.
  - Product-valid flag is cleared.
- FSM states: IDLE, LOAD, RUN, RESP (plus FUSE when MUL_FUSE_EN is defined).
- IDLE:
  - req_ready=1.
  - On req_valid, register the operands, op and zero flag, then go to LOAD.
- Operand extension, into two upper bits:
  - MUL and MULH: both operands sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both operands zero-extended.
- mu_res_sel = (op != MUL). It is registered at acceptance and held stable until the next acceptance.
- LOAD: mu_load=1 for exactly one cycle, mu_mact=0, then go to RUN.
- RUN:
  - mu_mact=1 until mu_done.
  - On mu_done: capture mu_result into rsp_data, drop mu_mact, go to RESP.
- Latency from the acceptance edge to rsp_valid:
  - Zero operand: 3 cycles (mu_done arrives in the first RUN cycle).
  - Non-zero operands, W=34: 19 cycles (mu_done on the 17th RUN cycle).
- RESP:
  - rsp_valid=1; rsp_data is held until rsp_valid && rsp_ready.
  - On that handshake go to IDLE.
  - req_ready stays 0 in RESP; there is no back-to-back accept in the same cycle.
- req_ready=0 in every state except IDLE.
- req_flush, any state:
  - Next state is IDLE.
  - rsp_valid and mu_mact go low on the next edge, and the product-valid flag is cleared.
  - Flush has priority over mu_done and over the rsp handshake in the same cycle.
- mu_done outside RUN is ignored.
- Reset mid-RUN fully aborts the operation; no stale rsp_valid may follow.

Optional Feature:
- Macro: ALU_MUL_CTRL_FUSE_EN.
- Defined:
  - A product-valid flag is set on a completed RUN; the last extended operands are retained.
  - A new request fuses when both of these hold:
    - rs1 and rs2 equal the stored operands.
    - Either the new op is MUL, or the new op's extension class equals the stored one.
  - Fused path: IDLE → FUSE → RESP.
  - In FUSE: mu_res_sel is updated, mu_mact=0, no mu_load, and mu_result is captured.
  - Latency is 2 cycles.
  - The flag is cleared by any mu_load, flush or reset.
- Undefined: the FUSE state and flag are absent, and every request takes the full LOAD/RUN path.

Decomposition:
- Package alu_mul_pkg holds:
  - the op encodings;
  - the FSM state encoding;
  - the XLEN and W defaults;
  - the extension-class encoding (SS, SU, UU).
- One sub-module, alu_mul_opext: a combinational operand extender (op, rs1, rs2 → mu_op_a, mu_op_b, extension class).

Test Plan:
- Reset with req_valid high → all outputs 0, req_ready=1; no acceptance while a_rst=0.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF with a unit model → mu_op_a=mu_op_b=0x0FFFFFFFF, mu_res_sel=1, rsp_data=0xFFFFFFFE at acceptance+19.
- MUL rs1=0, rs2=0x1234 → mu_zero=1, rsp_valid at acceptance+3, rsp_data=0.
- MULHSU rs1=0x80000000, rs2=0xFFFFFFFF, rsp_ready held low 5 cycles → rsp_data=0x80000000 held stable, req_ready=0 throughout, IDLE after the handshake.
- req_flush on the 8th RUN cycle of a MULH → mu_mact low next cycle, no rsp_valid, next request accepted the following cycle.
- With ALU_MUL_CTRL_FUSE_EN: MULH 0x7FFFFFFF×2 then MUL with the same operands → second rsp_data=0xFFFFFFFE at acceptance+2 with no mu_load pulse; without the macro → acceptance+19.

Source files
------------

// File: rtl/alu_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_pkg
// Description : Op, extension-class and FSM encodings for the multiply
//               sequencer. ALU_MUL_CTRL_FUSE_EN adds the FUSE state.
// Revision    : 1.0
// ============================================================================
package alu_mul_pkg;

   localparam int XLEN_DEF = 32;
   localparam int W_DEF    = 34;
   localparam int OPW_DEF  = 2;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      EXT_SS = 2'b00,
      EXT_SU = 2'b01,
      EXT_UU = 2'b10
   } ext_cls_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_RESP = 3'd3
`ifdef ALU_MUL_CTRL_FUSE_EN
      ,
      ST_FUSE = 3'd4
`endif
   } state_e;

   function automatic ext_cls_e op_class(input logic [1:0] op);
      case (op)
         OP_MULHSU: return EXT_SU;
         OP_MULHU:  return EXT_UU;
         default:   return EXT_SS;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_opext.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_opext
// Description : Combinational operand extender: widens rs1/rs2 to W bits
//               according to the op's signedness class.
// Revision    : 1.0
// ============================================================================
module alu_mul_opext
   import alu_mul_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int W    = W_DEF,
   parameter int OPW  = OPW_DEF
) (
   input  logic [OPW-1:0]  op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [W-1:0]    op_a_o,
   output logic [W-1:0]    op_b_o,
   output logic [1:0]      cls_o
);

   ext_cls_e w_cls;
   logic     w_sa;
   logic     w_sb;

   assign w_cls  = op_class(op_i);
   assign w_sa   = (w_cls != EXT_UU) & rs1_i[XLEN-1];
   assign w_sb   = (w_cls == EXT_SS) & rs2_i[XLEN-1];
   assign op_a_o = {{(W-XLEN){w_sa}}, rs1_i};
   assign op_b_o = {{(W-XLEN){w_sb}}, rs2_i};
   assign cls_o  = w_cls;

endmodule
`default_nettype wire

// File: rtl/alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_ctrl
// Description : Sequencer for the radix-4 Booth multiplier datapath.
//               Define ALU_MUL_CTRL_FUSE_EN to reuse a retained product.
// Revision    : 1.0
// ============================================================================
module alu_mul_ctrl
   import alu_mul_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int W    = W_DEF,
   parameter int OPW  = OPW_DEF
) (
   input  logic            clk,
   input  logic            a_rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OPW-1:0]  req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            req_flush,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic            busy,
   output logic            mu_load,
   output logic            mu_mact,
   output logic            mu_res_sel,
   output logic            mu_zero,
   output logic [W-1:0]    mu_op_a,
   output logic [W-1:0]    mu_op_b,
   input  logic            mu_done,
   input  logic [XLEN-1:0] mu_result
);

   state_e            state_q, state_d;
   logic [W-1:0]      op_a_q, op_b_q;
   logic [W-1:0]      w_op_a, w_op_b;
   logic [1:0]        w_cls;
   logic              res_sel_q, zero_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic              w_accept, w_capture, w_load_ops;

   alu_mul_opext #(.XLEN(XLEN), .W(W), .OPW(OPW)) u_opext (
      .op_i   (req_op),
      .rs1_i  (req_rs1),
      .rs2_i  (req_rs2),
      .op_a_o (w_op_a),
      .op_b_o (w_op_b),
      .cls_o  (w_cls)
   );

   // Flush outranks a new request arriving in the same IDLE cycle.
   assign w_accept = (state_q == ST_IDLE) && req_valid && !req_flush;

`ifdef ALU_MUL_CTRL_FUSE_EN
   logic       pvalid_q;
   logic [1:0] cls_q;
   logic       w_fuse;

   assign w_fuse = pvalid_q
                && (req_rs1 == op_a_q[XLEN-1:0])
                && (req_rs2 == op_b_q[XLEN-1:0])
                && ((req_op == OP_MUL) || (w_cls == cls_q));
   // The datapath still holds the old product, so its operands stay put.
   assign w_load_ops = w_accept && !w_fuse;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         pvalid_q <= 1'b0;
         cls_q    <= 2'b00;
      end else begin
         if (req_flush || (state_q == ST_LOAD)) begin
            pvalid_q <= 1'b0;
         end else if ((state_q == ST_RUN) && mu_done) begin
            pvalid_q <= 1'b1;
         end
         if (w_load_ops) begin
            cls_q <= w_cls;
         end
      end
   end
`else
   logic w_unused_cls;

   assign w_unused_cls = ^w_cls;
   assign w_load_ops   = w_accept;
`endif

   always_comb begin
      state_d   = state_q;
      w_capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef ALU_MUL_CTRL_FUSE_EN
               state_d = w_fuse ? ST_FUSE : ST_LOAD;
`else
               state_d = ST_LOAD;
`endif
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            if (mu_done) begin
               state_d   = ST_RESP;
               w_capture = 1'b1;
            end
         end
`ifdef ALU_MUL_CTRL_FUSE_EN
         ST_FUSE: begin
            state_d   = ST_RESP;
            w_capture = 1'b1;
         end
`endif
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (req_flush) begin
         state_d   = ST_IDLE;
         w_capture = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         state_q    <= ST_IDLE;
         op_a_q     <= '0;
         op_b_q     <= '0;
         res_sel_q  <= 1'b0;
         zero_q     <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            res_sel_q <= (req_op != OP_MUL);
            zero_q    <= (req_rs1 == '0) || (req_rs2 == '0);
         end
         if (w_load_ops) begin
            op_a_q <= w_op_a;
            op_b_q <= w_op_b;
         end
         if (w_capture) begin
            rsp_data_q <= mu_result;
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign mu_load    = (state_q == ST_LOAD);
   assign mu_mact    = (state_q == ST_RUN);
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_data   = rsp_data_q;
   assign mu_res_sel = res_sel_q;
   assign mu_zero    = zero_q;
   assign mu_op_a    = op_a_q;
   assign mu_op_b    = op_b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_ctrl
// Description : Self-checking bench for alu_mul_ctrl with a behavioural
//               multiplier-unit model and ISA-level result model.
// Revision    : 1.0
// ============================================================================
module tb_alu_mul_ctrl;

   logic        clk = 1'b0;
   logic        a_rst;
   logic        req_valid, req_ready, req_flush;
   logic [1:0]  req_op;
   logic [31:0] req_rs1, req_rs2;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic        busy, mu_load, mu_mact, mu_res_sel, mu_zero;
   logic [33:0] mu_op_a, mu_op_b;
   logic        mu_done;
   logic [31:0] mu_result;

   int checks = 0;
   int errors = 0;

`ifdef ALU_MUL_CTRL_FUSE_EN
   localparam bit FUSE_EN = 1'b1;
`else
   localparam bit FUSE_EN = 1'b0;
`endif

   alu_mul_ctrl dut (
      .clk(clk), .a_rst(a_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_flush(req_flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .mu_load(mu_load), .mu_mact(mu_mact),
      .mu_res_sel(mu_res_sel), .mu_zero(mu_zero),
      .mu_op_a(mu_op_a), .mu_op_b(mu_op_b),
      .mu_done(mu_done), .mu_result(mu_result)
   );

   always #5 clk = ~clk;

   // Iteration-unit model: done on RUN cycle 1 for a zero operand, else 17.
   int unsigned        u_cnt = 0;
   logic               done_inj = 1'b0;
   logic signed [67:0] u_prod;

   always @(posedge clk) begin
      if (mu_load) u_cnt <= 0;
      else if (mu_mact) u_cnt <= u_cnt + 1;
   end
   assign mu_done   = (mu_mact && (u_cnt == (mu_zero ? 0 : 16))) || done_inj;
   assign u_prod    = $signed(mu_op_a) * $signed(mu_op_b);
   assign mu_result = mu_res_sel ? u_prod[63:32] : u_prod[31:0];

   // Reference state for the fused-product behaviour.
   bit          pv = 1'b0;
   logic [31:0] s_a, s_b;
   int          s_cls;
   logic [33:0] s_ea, s_eb;

   function automatic int cls_of(input logic [1:0] op);
      return (op == 2'd3) ? 2 : (op == 2'd2) ? 1 : 0;
   endfunction

   function automatic logic [33:0] ext(input logic [31:0] v, input bit sgn);
      return sgn ? {{2{v[31]}}, v} : {2'b00, v};
   endfunction

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [65:0] x, y, p;
      x = (op == 2'd3) ? {34'd0, a} : {{34{a[31]}}, a};
      y = op[1] ? {34'd0, b} : {{34{b[31]}}, b};
      p = x * y;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
      bit          fused;
      int          exp_lat, lat, loads;
      logic [33:0] ea, eb;
      logic [31:0] exp_d;
      fused   = FUSE_EN && pv && (a == s_a) && (b == s_b) && ((op == 2'd0) || (cls_of(op) == s_cls));
      ea      = fused ? s_ea : ext(a, op != 2'd3);
      eb      = fused ? s_eb : ext(b, !op[1]);
      exp_d   = ref_res(op, a, b);
      exp_lat = fused ? 2 : (((a == 0) || (b == 0)) ? 3 : 19);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
      end
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
      @(negedge clk);
      req_valid = 1'b0; req_rs1 = $urandom; req_rs2 = $urandom; req_op = 2'($urandom_range(3));
      lat = 1; loads = 0;
      checks++;
      if ({mu_res_sel, mu_zero, mu_op_a, mu_op_b, busy} !== {op != 2'd0, (a == 0) || (b == 0), ea, eb, 1'b1}) begin
         errors++;
         $display("FAIL ctrl_regs op=%0d: got sel=%b zero=%b a=%h b=%h busy=%b want sel=%b zero=%b a=%h b=%h busy=1",
                  op, mu_res_sel, mu_zero, mu_op_a, mu_op_b, busy, op != 2'd0, (a == 0) || (b == 0), ea, eb);
      end
      while (rsp_valid !== 1'b1 && lat < 40) begin
         if (mu_load === 1'b1) loads++;
         checks++;
         if (req_ready !== 1'b0) begin
            errors++; $display("FAIL req_ready_busy at cycle %0d: got %b want 0", lat, req_ready);
         end
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL latency op=%0d a=%h b=%h: got %0d want %0d", op, a, b, lat, exp_lat);
      end
      checks++;
      if (rsp_data !== exp_d) begin
         errors++; $display("FAIL rsp_data op=%0d a=%h b=%h: got %h want %h", op, a, b, rsp_data, exp_d);
      end
      checks++;
      if (loads != (fused ? 0 : 1)) begin
         errors++; $display("FAIL load_pulses: got %0d want %0d", loads, fused ? 0 : 1);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, req_ready, rsp_data} !== {2'b10, exp_d}) begin
            errors++;
            $display("FAIL rsp_hold: got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                     rsp_valid, req_ready, rsp_data, exp_d);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         errors++; $display("FAIL post_handshake: got valid/ready/busy=%b want 010", {rsp_valid, req_ready, busy});
      end
      if (!fused) begin
         s_a = a; s_b = b; s_cls = cls_of(op); s_ea = ea; s_eb = eb;
      end
      pv = 1'b1;
   endtask

   task automatic test_reset();
      a_rst = 1'b0; req_valid = 1'b1; req_op = 2'd1; req_rs1 = 32'h5; req_rs2 = 32'h7;
      req_flush = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rsp_valid, busy, mu_load, mu_mact, mu_res_sel, mu_zero, rsp_data, mu_op_a, mu_op_b} !== '0
          || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b busy=%b load=%b mact=%b sel=%b zero=%b data=%h ready=%b want zeros ready=1",
                  rsp_valid, busy, mu_load, mu_mact, mu_res_sel, mu_zero, rsp_data, req_ready);
      end
      req_valid = 1'b0;
      a_rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, req_ready} !== 2'b01) begin
         errors++; $display("FAIL reset_release: got busy/ready=%b want 01", {busy, req_ready});
      end
      pv = 1'b0;
   endtask

   task automatic test_mulhu_max();
      do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_zero();
      do_op(2'd0, 32'h0, 32'h1234, 0);
   endtask

   task automatic test_backpressure();
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5);
   endtask

   task automatic test_fuse();
      do_op(2'd1, 32'h7FFF_FFFF, 32'h2, 0);
      do_op(2'd0, 32'h7FFF_FFFF, 32'h2, 1);
      do_op(2'd3, 32'h7FFF_FFFF, 32'h2, 0);
   endtask

   task automatic test_flush();
      req_valid = 1'b1; req_op = 2'd1; req_rs1 = 32'h1234_5678; req_rs2 = 32'h9ABC_DEF1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (mu_mact !== 1'b1) begin
         errors++; $display("FAIL flush_pre_mact: got %b want 1", mu_mact);
      end
      req_flush = 1'b1;
      @(negedge clk);
      req_flush = 1'b0;
      checks++;
      if ({mu_mact, rsp_valid, req_ready} !== 3'b001) begin
         errors++; $display("FAIL flush_mid_run: got mact/valid/ready=%b want 001", {mu_mact, rsp_valid, req_ready});
      end
      pv = 1'b0;
      do_op(2'd0, 32'h0000_0003, 32'hFFFF_FFFD, 0);
      // Flush coinciding with mu_done must still abort.
      req_valid = 1'b1; req_op = 2'd3; req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'h0000_1001;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (17) @(negedge clk);
      req_flush = 1'b1;
      @(negedge clk);
      req_flush = 1'b0;
      checks++;
      if ({rsp_valid, busy, mu_mact} !== 3'b000) begin
         errors++; $display("FAIL flush_vs_done: got valid/busy/mact=%b want 000", {rsp_valid, busy, mu_mact});
      end
      pv = 1'b0;
   endtask

   task automatic test_spurious_done();
      done_inj = 1'b1;
      @(negedge clk);
      done_inj = 1'b0;
      checks++;
      if ({busy, rsp_valid, req_ready} !== 3'b001) begin
         errors++; $display("FAIL idle_done_ignored: got busy/valid/ready=%b want 001", {busy, rsp_valid, req_ready});
      end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      req_valid = 1'b1; req_op = 2'd2; req_rs1 = 32'h0BAD_F00D; req_rs2 = 32'h0000_0777;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 a_rst = 1'b0;
      #1;
      checks++;
      if ({busy, mu_mact, rsp_valid, mu_op_a, req_ready} !== {37'd0, 1'b1}) begin
         errors++; $display("FAIL async_reset: got busy=%b mact=%b valid=%b op_a=%h ready=%b want 0,0,0,0,1",
                            busy, mu_mact, rsp_valid, mu_op_a, req_ready);
      end
      @(negedge clk);
      a_rst = 1'b1;
      pv = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL stale_after_reset: got activity=1 want 0");
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] a, b;
      a = pick(); b = pick();
      for (int i = 0; i < 24; i++) begin
         if (i == 0 || $urandom_range(2) != 0) begin
            a = pick(); b = pick();
         end
         do_op(2'($urandom_range(3)), a, b, $urandom_range(3));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_mulhu_max();
      test_zero();
      test_backpressure();
      test_fuse();
      test_flush();
      test_spurious_done();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
